cios_reduce_pe: RTL and testbench

- Downstream neighbour of the Montgomery m-generation PE in the CIOS datapath.
- Consumes that stage's m and carry-out (COut).
- Sweeps the remaining modulus words j = 1..words-1, computing (C,S) = t[j] + m*p[j] + C and emitting the shifted accumulator t[0..words] as a word stream with valid/ready handshakes.
- Closes each outer CIOS iteration by folding the two top words of t.

---
 rtl/cios_pkg.sv | 20 ++
 rtl/cios_mac.sv | 26 ++
 rtl/cios_reduce_pe.sv | 182 ++++++++++++++++++
 tb/tb_cios_reduce_pe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cios_pkg.sv
// Shared definitions for the CIOS Montgomery datapath PEs: controller state
// encoding and the sizing rule for the modulus-word index counter.
package cios_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FIN_S = 3'd2,
        FIN_C = 3'd3,
        WAIT  = 3'd4
    } state_t;

    // Index counter must reach words-1 and still have headroom for the +1.
    function automatic int calc_j_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int j_width_default = calc_j_width(8);

endpackage

// File: rtl/cios_mac.sv
// Combinational word MAC: {c_out, s} = t + a*b + c. The result fits in
// 2*width bits because (2^w-1) + (2^w-1)^2 + (2^w-1) = 2^(2w) - 1.
module cios_mac #(
    parameter int width = 32
) (
    input  logic [width-1:0] t,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic [width-1:0] c,
    output logic [width-1:0] s,
    output logic [width-1:0] c_out
);

    logic [2*width-1:0] sum;

    // Full double-width multiply-accumulate; no overflow is possible.
    always_comb begin
        sum = {{width{1'b0}}, t}
            + ({{width{1'b0}}, a} * {{width{1'b0}}, b})
            + {{width{1'b0}}, c};
    end

    assign s     = sum[width-1:0];
    assign c_out = sum[2*width-1:width];

endmodule

// File: rtl/cios_reduce_pe.sv
// CIOS reduction PE: sweeps j = 1..words-1 computing t[j] + m*p[j] + C,
// streams the shifted accumulator t[0..words], then folds the top two words.
// Optional build macro CIOS_REDUCE_STALL_CNT_EN adds a saturating count of
// output stall cycles (stall_cnt), cleared on every accepted start.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for en; captures m, C, t[s], t[s+1]
// RUN   | one MAC beat per accepted input, j = 1..words-1
// FIN_S | emit S of t[s] + C, keep the carry
// FIN_C | emit t[s+1] + carry as the last word
// WAIT  | hold last word until the consumer takes it, then pulse done
module cios_reduce_pe
    import cios_pkg::*;
#(
    parameter int width = 32,
    parameter int words = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [width-1:0] m,
    input  logic [width-1:0] c_in,
    input  logic [width-1:0] t_top,
    input  logic [width-1:0] t_top1,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] t_in,
    input  logic [width-1:0] p_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_word,
    output logic             out_last,
    output logic             busy,
    output logic             done
`ifdef CIOS_REDUCE_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    localparam int jw = calc_j_width(words);

    generate
        if (words < 2) begin : g_bad_words
            $error("cios_reduce_pe: words must be at least 2");
        end
    endgenerate

    state_t           state, state_next;
    logic [width-1:0] m_r, c_r, top_r, top1_r;
    logic [jw-1:0]    j_r;
    logic             cy_r;
    logic             slot_free, start, load, load_last, fin_done;
    logic [width-1:0] load_word;
    logic [width-1:0] mac_s, mac_c;
    logic [width:0]   fin_sum;

    cios_mac #(.width(width)) u_mac (
        .t     (t_in),
        .a     (m_r),
        .b     (p_in),
        .c     (c_r),
        .s     (mac_s),
        .c_out (mac_c)
    );

    // Single-entry output register can take a new word if empty or draining.
    assign slot_free = !out_valid || out_ready;
    assign fin_sum   = {1'b0, top_r} + {1'b0, c_r};
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and load decisions for the output slot.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        start      = 1'b0;
        load       = 1'b0;
        load_word  = mac_s;
        load_last  = 1'b0;
        fin_done   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    load = 1'b1;
                    if (j_r == jw'(words - 1)) state_next = FIN_S;
                end
            end
            FIN_S: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_word  = fin_sum[width-1:0];
                    state_next = FIN_C;
                end
            end
            FIN_C: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_word  = top1_r + width'(cy_r);
                    load_last  = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (out_valid && out_ready) begin
                    fin_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture at start, running carry and index during the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r    <= '0;
            c_r    <= '0;
            top_r  <= '0;
            top1_r <= '0;
            j_r    <= '0;
            cy_r   <= 1'b0;
        end else begin
            if (start) begin
                m_r    <= m;
                c_r    <= c_in;
                top_r  <= t_top;
                top1_r <= t_top1;
                j_r    <= jw'(1);
                cy_r   <= 1'b0;
            end
            if (state == RUN && load) begin
                c_r <= mac_c;
                j_r <= j_r + jw'(1);
            end
            if (state == FIN_S && load) cy_r <= fin_sum[width];
        end
    end

    // Output slot: load wins over drain so load+drain gives full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_word  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= fin_done;
            if (load) begin
                out_word  <= load_word;
                out_valid <= 1'b1;
                out_last  <= load_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef CIOS_REDUCE_STALL_CNT_EN
    // Saturating count of cycles the consumer held off a valid word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          stall_cnt <= '0;
        else if (start)                                   stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_cios_reduce_pe.sv
// Directed bench for cios_reduce_pe at width=8, words=4.
module tb_cios_reduce_pe;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst, en, in_valid, out_ready;
    logic [W-1:0] m, c_in, t_top, t_top1, t_in, p_in;
    logic         in_ready, out_valid, out_last, busy, done;
    logic [W-1:0] out_word;
`ifdef CIOS_REDUCE_STALL_CNT_EN
    logic [31:0]  stall_cnt;
`endif

    cios_reduce_pe #(.width(W), .words(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .m         (m),
        .c_in      (c_in),
        .t_top     (t_top),
        .t_top1    (t_top1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .t_in      (t_in),
        .p_in      (p_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef CIOS_REDUCE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] tv[3], pv[3], exp_w[5];
    logic [W-1:0] got_w[$];
    logic         got_l[$];
    int           cyc = 0, last_cyc = -100, done_cyc = 0, done_n = 0;
    logic         prev_stall = 1'b0, prev_last = 1'b0;
    logic [W-1:0] prev_word = '0;
    int           rdy_mode = 0, rdy_k = 0, stall_left = 0;
    logic [3:0]   rdy_pat = 4'b1001;
    logic         abort = 1'b0;

    // Output monitor: collects handshakes, checks stall behaviour.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_word", out_word, prev_word);
                    check("hold_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    got_w.push_back(out_word);
                    got_l.push_back(out_last);
                    if (out_last) last_cyc = cyc;
                end
                if (done) begin
                    done_n++;
                    done_cyc = cyc;
                end
                prev_stall = out_valid && !out_ready;
                prev_word  = out_word;
                prev_last  = out_last;
            end
        end
    end

    // Consumer ready pattern: 0 always ready, 1 toggling 1-0-0-1, 2 fixed stall burst.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    out_ready = rdy_pat[3 - (rdy_k % 4)];
                    rdy_k++;
                end
                2: begin
                    if (stall_left > 0 && out_valid) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_iter(input logic [W-1:0] mv, input logic [W-1:0] cv,
                              input logic [W-1:0] tt, input logic [W-1:0] tt1);
        en = 1'b1; m = mv; c_in = cv; t_top = tt; t_top1 = tt1;
        @(posedge clk); #1;
        en = 1'b0; m = 8'hAA; c_in = 8'h55; t_top = 8'h3C; t_top1 = 8'hC3;
    endtask

    task automatic feed(input int gap, input bit spur);
        int  budget;
        bit  took;
        for (int i = 0; i < N - 1; i++) begin
            if (abort) break;
            budget = 0;
            took   = 1'b0;
            in_valid = 1'b1; t_in = tv[i]; p_in = pv[i];
            while (!took && !abort) begin
                @(negedge clk);
                if (in_ready) took = 1'b1;
                @(posedge clk); #1;
                budget++;
                if (!took && budget > 60) begin
                    check("feed_timeout", 1, 0);
                    abort = 1'b1;
                end
            end
            in_valid = 1'b0; t_in = 8'hEE; p_in = 8'hEE;
            if (i < N - 2) begin
                for (int g = 0; g < gap; g++) begin
                    if (spur && g == 0) begin en = 1'b1; m = 8'h77; c_in = 8'h77; end
                    @(posedge clk); #1;
                    en = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int b;
        b = 0;
        while (done_n == d0 && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        check("done_seen", done_n - d0, 1);
        @(posedge clk); #1;
        check("done_single", done_n - d0, 1);
    endtask

    task automatic check_run(input string name);
        check({name, "_count"}, got_w.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_w.size()) begin
                check({name, "_word"}, got_w[i], exp_w[i]);
                check({name, "_last"}, got_l[i], (i == 4));
            end
        end
        check({name, "_done_lat"}, done_cyc - last_cyc, 1);
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic set_basic();
        tv = '{8'h05, 8'h06, 8'h07};
        pv = '{8'h10, 8'h20, 8'h30};
        exp_w = '{8'h36, 8'h66, 8'h97, 8'hFF, 8'h00};
    endtask

    task automatic run_basic(input string name, input int gap, input bit spur);
        int d0;
        set_basic();
        got_w.delete(); got_l.delete();
        d0 = done_n;
        start_iter(8'h03, 8'h01, 8'hFF, 8'h00);
        check({name, "_busy"}, busy, 1);
        feed(gap, spur);
        wait_done(d0);
        check_run(name);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0;
        m = '0; c_in = '0; t_top = '0; t_top1 = '0; t_in = '0; p_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_word", out_word, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_basic("basic", 0, 1'b0);

        // Carry chain through every word and the final fold.
        begin
            int d0;
            tv = '{8'hFF, 8'hFF, 8'hFF};
            pv = '{8'hFF, 8'hFF, 8'hFF};
            exp_w = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h01};
            got_w.delete(); got_l.delete();
            d0 = done_n;
            start_iter(8'hFF, 8'hFF, 8'h01, 8'h00);
            feed(0, 1'b0);
            wait_done(d0);
            check_run("carry");
        end

        rdy_mode = 1; rdy_k = 0;
        run_basic("bp", 0, 1'b0);
        rdy_mode = 0;
        @(posedge clk); #1;

        // Spurious in_valid while idle must not be consumed.
        got_w.delete(); got_l.delete();
        in_valid = 1'b1; t_in = 8'h11; p_in = 8'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("idle_no_beats", got_w.size(), 0);
        run_basic("gaps", 3, 1'b1);

        // Asynchronous reset after the second output beat.
        set_basic();
        got_w.delete(); got_l.delete();
        start_iter(8'h03, 8'h01, 8'hFF, 8'h00);
        fork
            feed(0, 1'b0);
            begin
                int b;
                b = 0;
                while (got_w.size() < 2 && b < 50) begin
                    @(negedge clk);
                    b++;
                end
                check("rst_mid_reach", got_w.size() >= 2, 1);
                #2;
                rst = 1'b1;
                abort = 1'b1;
                #1;
                check("rst_mid_valid", out_valid, 0);
                check("rst_mid_word", out_word, 0);
                check("rst_mid_last", out_last, 0);
                check("rst_mid_busy", busy, 0);
                check("rst_mid_ready", in_ready, 0);
                check("rst_mid_done", done, 0);
            end
        join
        @(posedge clk); #1;
        rst = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", busy, 0);
        run_basic("after_rst", 0, 1'b0);

`ifdef CIOS_REDUCE_STALL_CNT_EN
        rdy_mode = 2; stall_left = 4;
        run_basic("stall", 0, 1'b0);
        check("stall_cnt_4", stall_cnt, 4);
        rdy_mode = 0;
        begin
            int d0;
            set_basic();
            got_w.delete(); got_l.delete();
            d0 = done_n;
            start_iter(8'h03, 8'h01, 8'hFF, 8'h00);
            check("stall_cnt_clr", stall_cnt, 0);
            feed(0, 1'b0);
            wait_done(d0);
            check_run("stall_next");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
